// File: rtl/i2s_tdm_slot_scheduler.sv
// I2S/TDM frame-sync tracker and slot scheduler; locks to the LRCLK rising edge and emits one framed sample per enabled slot.
// Optional build macro I2S_TDM_FLYWHEEL_EN bridges a single missing frame edge while locked.
module i2s_tdm_slot_scheduler #(
    parameter int SLOT_WIDTH  = 24,
    parameter int SLOT_BITS   = 32,
    parameter int NUM_SLOTS   = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                                                    i2s_bclk,
    input  logic                                                    sys_rst,
    input  logic                                                    enable,
    input  logic                                                    i2s_lrclk,
    input  logic                                                    i2s_data,
    input  logic [NUM_SLOTS-1:0]                                    channel_mask,
    output logic [SLOT_WIDTH-1:0]                                   slot_data,
    output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0]    slot_idx,
    output logic                                                    slot_valid,
    output logic                                                    frame_start,
    output logic                                                    locked,
    output logic                                                    sync_lost,
    output logic [7:0]                                              err_count
);

    localparam int IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int BIT_W  = $clog2(SLOT_BITS);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKING,
        LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
    logic                    prev_lrclk_q;
    logic [SLOT_WIDTH-2:0]   shift_q;
    logic [SLOT_WIDTH-1:0]   shift_full;

    logic [SLOT_WIDTH-1:0]   slot_data_q, slot_data_d;
    logic [IDX_W-1:0]        slot_idx_q, slot_idx_d;
    logic                    slot_valid_q, slot_valid_d;
    logic                    frame_start_q, frame_start_d;
    logic                    locked_q, locked_d;
    logic                    sync_lost_q, sync_lost_d;
    logic [7:0]              err_count_q, err_count_d;

`ifdef I2S_TDM_FLYWHEEL_EN
    logic                    miss_q, miss_d;
`endif

    logic                    frame_edge;
    logic                    frame_end;
    logic                    capture_point;
    logic                    realign;
    logic                    loss;

    assign frame_edge    = ~prev_lrclk_q & i2s_lrclk;
    assign frame_end     = (slot_cnt_q == IDX_W'(NUM_SLOTS - 1)) && (bit_cnt_q == BIT_W'(SLOT_BITS - 1));
    assign capture_point = (bit_cnt_q == BIT_W'(SLOT_WIDTH - 1));
    assign shift_full    = {shift_q, i2s_data};

    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            good_cnt_q    <= '0;
            prev_lrclk_q  <= 1'b0;
            shift_q       <= '0;
            slot_data_q   <= '0;
            slot_idx_q    <= '0;
            slot_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_lost_q   <= 1'b0;
            err_count_q   <= '0;
`ifdef I2S_TDM_FLYWHEEL_EN
            miss_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            good_cnt_q    <= good_cnt_d;
            prev_lrclk_q  <= i2s_lrclk;
            shift_q       <= shift_full[SLOT_WIDTH-2:0];
            slot_data_q   <= slot_data_d;
            slot_idx_q    <= slot_idx_d;
            slot_valid_q  <= slot_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_lost_q   <= sync_lost_d;
            err_count_q   <= err_count_d;
`ifdef I2S_TDM_FLYWHEEL_EN
            miss_q        <= miss_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q + BIT_W'(1);
        slot_cnt_d    = slot_cnt_q;
        good_cnt_d    = good_cnt_q;
        frame_start_d = 1'b0;
        realign       = 1'b0;
        loss          = 1'b0;
`ifdef I2S_TDM_FLYWHEEL_EN
        miss_d        = miss_q;
`endif

        if (bit_cnt_q == BIT_W'(SLOT_BITS - 1)) begin
            bit_cnt_d  = '0;
            slot_cnt_d = (slot_cnt_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : slot_cnt_q + IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = HUNT;
                end
            end
            HUNT: begin
                if (frame_edge) begin
                    realign    = 1'b1;
                    good_cnt_d = '0;
                    state_d    = LOCKING;
                end
            end
            LOCKING: begin
                if (frame_edge) begin
                    realign = 1'b1;
                    if (frame_end) begin
                        if (good_cnt_q == GOOD_W'(LOCK_FRAMES - 1)) begin
                            state_d       = LOCKED;
                            frame_start_d = 1'b1;
                            good_cnt_d    = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (frame_end) begin
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                if (frame_edge) begin
                    realign = 1'b1;
                    if (frame_end) begin
                        frame_start_d = 1'b1;
`ifdef I2S_TDM_FLYWHEEL_EN
                        miss_d        = 1'b0;
`endif
                    end else begin
                        loss       = 1'b1;
                        good_cnt_d = '0;
                        state_d    = LOCKING;
                    end
                end else if (frame_end) begin
`ifdef I2S_TDM_FLYWHEEL_EN
                    // First missing edge is treated as a phantom aligned edge; pos simply wraps.
                    if (!miss_q) begin
                        miss_d = 1'b1;
                    end else begin
                        loss    = 1'b1;
                        state_d = HUNT;
                    end
`else
                    loss    = 1'b1;
                    state_d = HUNT;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (realign) begin
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
        end

        // A capture completing on the same posedge as a sync error is discarded.
        slot_valid_d = (state_q == LOCKED) && capture_point && channel_mask[slot_cnt_q] && !loss;
        slot_data_d  = slot_valid_d ? shift_full : slot_data_q;
        slot_idx_d   = slot_valid_d ? slot_cnt_q : slot_idx_q;
        sync_lost_d  = loss;
        err_count_d  = (loss && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;

        if (!enable) begin
            state_d       = IDLE;
            frame_start_d = 1'b0;
            slot_valid_d  = 1'b0;
            slot_data_d   = slot_data_q;
            slot_idx_d    = slot_idx_q;
            sync_lost_d   = 1'b0;
            err_count_d   = err_count_q;
        end

        locked_d = (state_d == LOCKED);
`ifdef I2S_TDM_FLYWHEEL_EN
        if (state_d != LOCKED) begin
            miss_d = 1'b0;
        end
`endif
    end

    assign slot_data   = slot_data_q;
    assign slot_idx    = slot_idx_q;
    assign slot_valid  = slot_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_lost   = sync_lost_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_i2s_tdm_slot_scheduler.sv
// Self-checking bench for i2s_tdm_slot_scheduler: random frames compared against a frame-level reference model.
// Honours I2S_TDM_FLYWHEEL_EN when the design is built with it.
module tb_i2s_tdm_slot_scheduler;

    localparam int NS = 2;
    localparam int SB = 32;
    localparam int SW = 24;
    localparam int LF = 2;
    localparam int FB = NS * SB;

    logic        i2s_bclk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic [1:0]  channel_mask;
    logic [23:0] slot_data;
    logic [0:0]  slot_idx;
    logic        slot_valid;
    logic        frame_start;
    logic        locked;
    logic        sync_lost;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: whether the scheduler is locked, whether it knows the frame phase, edges counted, errors.
    bit m_locked = 0;
    bit m_phase  = 0;
    int m_good   = 0;
    int m_err    = 0;
    bit m_miss   = 0;

    typedef struct packed {
        logic [7:0]  n_valid;
        logic [31:0] ev0;
        logic [31:0] ev1;
        logic [7:0]  n_fs;
        logic [6:0]  fs_pos;
        logic [7:0]  n_sl;
        logic [6:0]  sl_pos;
        logic        locked_mid;
        logic        locked_end;
        logic [7:0]  err_end;
    } frame_obs_t;

    i2s_tdm_slot_scheduler #(
        .SLOT_WIDTH (SW),
        .SLOT_BITS  (SB),
        .NUM_SLOTS  (NS),
        .LOCK_FRAMES(LF)
    ) dut (
        .i2s_bclk    (i2s_bclk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .channel_mask(channel_mask),
        .slot_data   (slot_data),
        .slot_idx    (slot_idx),
        .slot_valid  (slot_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_lost   (sync_lost),
        .err_count   (err_count)
    );

    always #5 i2s_bclk = ~i2s_bclk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic bit_cycle(input logic lr, input logic d);
        i2s_lrclk = lr;
        i2s_data  = d;
        @(posedge i2s_bclk);
        #1;
    endtask

    // Drives one frame of len bits; an lrclk pulse on the last bit when has_edge.
    task automatic send_frame(input logic [23:0] w0, input logic [23:0] w1, input int len,
                              input bit has_edge, output frame_obs_t obs);
        logic [23:0] w;
        logic        d;
        int          s;
        int          b;
        obs = '0;
        for (int p = 0; p < len; p++) begin
            s = p / SB;
            b = p % SB;
            w = (s == 0) ? w0 : w1;
            d = (b < SW) ? w[SW-1-b] : 1'($urandom_range(0, 1));
            bit_cycle(has_edge && (p == len - 1), d);
            if (slot_valid) begin
                if (obs.n_valid == 8'd0) obs.ev0 = {7'(p), slot_idx, slot_data};
                else if (obs.n_valid == 8'd1) obs.ev1 = {7'(p), slot_idx, slot_data};
                obs.n_valid = obs.n_valid + 8'd1;
            end
            if (frame_start) begin
                obs.n_fs   = obs.n_fs + 8'd1;
                obs.fs_pos = 7'(p);
            end
            if (sync_lost) begin
                obs.n_sl   = obs.n_sl + 8'd1;
                obs.sl_pos = 7'(p);
            end
            if (p == 0) obs.locked_mid = locked;
        end
        obs.locked_end = locked;
        obs.err_end    = err_count;
    endtask

    function automatic frame_obs_t model_frame(input logic [23:0] w0, input logic [23:0] w1, input int len,
                                               input bit has_edge, input logic [1:0] mask);
        frame_obs_t  e;
        bit          aligned, misaligned, missing, bridged, lost;
        int          p;
        logic [23:0] w;
        e          = '0;
        aligned    = has_edge && (len == FB);
        misaligned = has_edge && (len != FB);
        missing    = !has_edge;
        bridged    = 0;
`ifdef I2S_TDM_FLYWHEEL_EN
        bridged    = m_locked && missing && !m_miss;
`endif
        lost = m_locked && (misaligned || (missing && !bridged));
        e.locked_mid = m_locked;
        if (m_locked) begin
            for (int s = 0; s < NS; s++) begin
                p = s * SB + SW - 1;
                w = (s == 0) ? w0 : w1;
                if (p < len && mask[s] && !(lost && p == len - 1)) begin
                    if (e.n_valid == 8'd0) e.ev0 = {7'(p), 1'(s), w};
                    else e.ev1 = {7'(p), 1'(s), w};
                    e.n_valid = e.n_valid + 8'd1;
                end
            end
        end
        if (lost) begin
            e.n_sl   = 8'd1;
            e.sl_pos = 7'(len - 1);
            if (m_err < 255) m_err++;
        end
        if (m_locked) begin
            if (aligned) begin
                e.n_fs = 8'd1; e.fs_pos = 7'(FB - 1); m_miss = 0;
            end else if (bridged) begin
                m_miss = 1;
            end else if (misaligned) begin
                m_locked = 0; m_phase = 1; m_good = 0; m_miss = 0;
            end else begin
                m_locked = 0; m_phase = 0; m_miss = 0;
            end
        end else if (m_phase) begin
            if (aligned) begin
                m_good++;
                if (m_good == LF) begin
                    m_locked = 1; e.n_fs = 8'd1; e.fs_pos = 7'(FB - 1);
                end
            end else if (misaligned) begin
                m_good = 0;
            end else begin
                m_phase = 0;
            end
        end else if (has_edge) begin
            m_phase = 1; m_good = 0;
        end
        e.locked_end = m_locked;
        e.err_end    = 8'(m_err);
        return e;
    endfunction

    task automatic test_reset();
        logic [36:0] outs;
        sys_rst = 1'b1; enable = 1'b0; i2s_lrclk = 1'b0; i2s_data = 1'b0; channel_mask = 2'b11;
        #23;
        outs = {slot_data, slot_idx, slot_valid, frame_start, locked, sync_lost, err_count};
        checks++;
        if (outs !== '0) begin
            failures++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        @(negedge i2s_bclk);
        sys_rst = 1'b0;
        outs = '0;
        for (int p = 0; p < 80; p++) begin
            bit_cycle((p % 16) == 15, 1'($urandom_range(0, 1)));
            outs = outs | {slot_data, slot_idx, slot_valid, frame_start, locked, sync_lost, err_count};
        end
        checks++;
        if (outs !== '0) begin
            failures++; $display("[TB] FAIL idle_quiet: got %h expected 0", outs);
        end
        enable = 1'b1;
        bit_cycle(1'b0, 1'b0);
        bit_cycle(1'b0, 1'b0);
    endtask

    task automatic test_lock();
        frame_obs_t  obs, exp;
        logic [23:0] w0, w1;
        channel_mask = 2'b11;
        for (int i = 0; i < 5; i++) begin
            w0 = (i == 3) ? 24'hA5A5A5 : 24'($urandom());
            w1 = (i == 3) ? 24'h123456 : 24'($urandom());
            send_frame(w0, w1, FB, 1, obs);
            exp = model_frame(w0, w1, FB, 1, channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL lock frame %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_masking();
        frame_obs_t  obs, exp;
        logic [23:0] w0, w1;
        for (int i = 0; i < 6; i++) begin
            channel_mask = (i < 2) ? 2'b10 : 2'($urandom_range(0, 3));
            w0 = 24'($urandom());
            w1 = 24'($urandom());
            send_frame(w0, w1, FB, 1, obs);
            exp = model_frame(w0, w1, FB, 1, channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL mask frame %0d mask %b: got %h expected %h", i, channel_mask, obs, exp);
            end
        end
        channel_mask = 2'b11;
    endtask

    task automatic test_misaligned();
        frame_obs_t  obs, exp;
        logic [23:0] w0, w1;
        int          len;
        for (int i = 0; i < 16; i++) begin
            w0  = 24'($urandom());
            w1  = 24'($urandom());
            len = FB;
            if (i % 4 == 0) len = (i == 0) ? 41 : ((i == 4) ? 24 : $urandom_range(2, FB - 1));
            send_frame(w0, w1, len, 1, obs);
            exp = model_frame(w0, w1, len, 1, channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL misaligned frame %0d len %0d: got %h expected %h", i, len, obs, exp);
            end
        end
    endtask

    task automatic test_missing();
        frame_obs_t  obs, exp;
        logic [23:0] w0, w1;
        bit          pattern [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            w0 = 24'($urandom());
            w1 = 24'($urandom());
            send_frame(w0, w1, FB, pattern[i], obs);
            exp = model_frame(w0, w1, FB, pattern[i], channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL missing frame %0d edge %0d: got %h expected %h", i, pattern[i], obs, exp);
            end
        end
    endtask

    task automatic test_enable_reset();
        frame_obs_t  obs, exp;
        logic [23:0] w0, w1;
        logic [36:0] outs;
        logic [3:0]  strobes;
        int          guard;
        guard = 0;
        while (!m_locked && guard < 6) begin
            w0 = 24'($urandom()); w1 = 24'($urandom());
            send_frame(w0, w1, FB, 1, obs);
            exp = model_frame(w0, w1, FB, 1, channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL enable_prelock frame %0d: got %h expected %h", guard, obs, exp);
            end
            guard++;
        end
        for (int p = 0; p < 10; p++) bit_cycle(1'b0, 1'($urandom_range(0, 1)));
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("[TB] FAIL enable_locked_before: got %b expected 1", locked);
        end
        enable = 1'b0;
        bit_cycle(1'b0, 1'b1);
        checks++;
        if ({slot_valid, frame_start, locked, sync_lost, err_count} !== {4'b0000, 8'(m_err)}) begin
            failures++;
            $display("[TB] FAIL enable_drop: got %b/%0d expected 0000/%0d",
                     {slot_valid, frame_start, locked, sync_lost}, err_count, m_err);
        end
        strobes = '0;
        for (int p = 0; p < 70; p++) begin
            bit_cycle((p % 64) == 20, 1'($urandom_range(0, 1)));
            strobes = strobes | {slot_valid, frame_start, locked, sync_lost};
        end
        checks++;
        if ({strobes, err_count} !== {4'b0000, 8'(m_err)}) begin
            failures++; $display("[TB] FAIL disabled_quiet: got %b/%0d expected 0000/%0d", strobes, err_count, m_err);
        end
        m_locked = 0; m_phase = 0; m_good = 0; m_miss = 0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w0 = 24'($urandom()); w1 = 24'($urandom());
            send_frame(w0, w1, FB, 1, obs);
            exp = model_frame(w0, w1, FB, 1, channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL reenable frame %0d: got %h expected %h", i, obs, exp);
            end
        end
        for (int p = 0; p < 30; p++) bit_cycle(1'b0, 1'($urandom_range(0, 1)));
        #1;
        sys_rst = 1'b1;
        #1;
        outs = {slot_data, slot_idx, slot_valid, frame_start, locked, sync_lost, err_count};
        checks++;
        if (outs !== '0) begin
            failures++; $display("[TB] FAIL async_reset: got %h expected 0", outs);
        end
        bit_cycle(1'b0, 1'b0);
        bit_cycle(1'b0, 1'b0);
        sys_rst = 1'b0;
        m_locked = 0; m_phase = 0; m_good = 0; m_miss = 0; m_err = 0;
        bit_cycle(1'b0, 1'b0);
        checks++;
        if ({locked, err_count} !== 9'd0) begin
            failures++; $display("[TB] FAIL post_reset: got locked %b err %0d expected 0/0", locked, err_count);
        end
    endtask

    task automatic test_saturation();
        frame_obs_t  obs, exp;
        logic [23:0] w0, w1;
        int          len;
        int          guard;
        for (int n = 0; n < 260; n++) begin
            guard = 0;
            while (!m_locked && guard < 6) begin
                w0 = 24'($urandom()); w1 = 24'($urandom());
                send_frame(w0, w1, FB, 1, obs);
                exp = model_frame(w0, w1, FB, 1, channel_mask);
                checks++;
                if (obs !== exp) begin
                    failures++; $display("[TB] FAIL sat_lock loss %0d: got %h expected %h", n, obs, exp);
                end
                guard++;
            end
            if (!m_locked) begin
                failures++; $display("[TB] FAIL sat_relock_bound: loss %0d no lock after %0d frames", n, guard);
            end
            w0 = 24'($urandom()); w1 = 24'($urandom());
            len = $urandom_range(2, 20);
            send_frame(w0, w1, len, 1, obs);
            exp = model_frame(w0, w1, len, 1, channel_mask);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL sat_loss %0d len %0d: got %h expected %h", n, len, obs, exp);
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            failures++; $display("[TB] FAIL err_saturated: got %0d expected 255", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_masking();
        test_misaligned();
        test_missing();
        test_enable_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
